// File: rtl/uart_program_loader.sv
// UART byte stream to imem loader: word count, then N 16-bit words, LSB first.
// Optional trailing checksum word when LOADER_CHECKSUM_EN is defined.
module uart_program_loader #(
    parameter int ADDR_W         = 8,
    parameter int MAX_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              wait_transport,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = ADDR_W + 1;
    localparam logic [16:0] MAXW = 17'(MAX_WORDS);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, GET_CNT, GET_INSTR, GET_CSUM, DONE, ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, GET_CNT, GET_INSTR, DONE, ERR
    } state_t;
`endif

    state_t            state_q;
    logic              ws1_q, ws2_q, ws3_q;
    logic              phase_q;
    logic [7:0]        lo_q;
    logic [IW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [TW-1:0]     timer_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              hold_q;
    logic              done_q;
    logic              err_q;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]       sum_q;
`endif

    logic          fall;
    logic          loading;
    logic          word_done;
    logic [15:0]   word;
    logic [IW-1:0] idx_d;

    // Sync chain idles high so reset release never looks like a press
    assign fall      = ws3_q & ~ws2_q;
    assign loading   = (state_q == GET_CNT) || (state_q == GET_INSTR)
`ifdef LOADER_CHECKSUM_EN
                       || (state_q == GET_CSUM)
`endif
                       ;
    assign word_done = rx_valid & phase_q;
    assign word      = {rx_data, lo_q};
    assign idx_d     = idx_q + 1'b1;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            ws1_q   <= 1'b1;
            ws2_q   <= 1'b1;
            ws3_q   <= 1'b1;
            phase_q <= 1'b0;
            lo_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            ws1_q <= wait_transport;
            ws2_q <= ws1_q;
            ws3_q <= ws2_q;
            we_q  <= 1'b0;
            if (fall) begin
                state_q <= GET_CNT;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                idx_q   <= '0;
                phase_q <= 1'b0;
                hold_q  <= 1'b1;
                timer_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum_q   <= '0;
`endif
            end else if (loading) begin
                if (rx_valid) begin
                    timer_q <= '0;
                    phase_q <= ~phase_q;
                    if (!phase_q) lo_q <= rx_data;
                end else if (timer_q == TLAST) begin
                    state_q <= ERR;
                    hold_q  <= 1'b0;
                    err_q   <= 1'b1;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
                if (word_done) begin
                    unique case (state_q)
                        GET_CNT: begin
                            if (word == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q <= GET_CSUM;
`else
                                state_q <= DONE;
                                hold_q  <= 1'b0;
                                done_q  <= 1'b1;
`endif
                            end else if ({1'b0, word} > MAXW) begin
                                state_q <= ERR;
                                hold_q  <= 1'b0;
                                err_q   <= 1'b1;
                            end else begin
                                cnt_q   <= word[IW-1:0];
                                state_q <= GET_INSTR;
                            end
                        end
                        GET_INSTR: begin
                            we_q    <= 1'b1;
                            addr_q  <= idx_q[ADDR_W-1:0];
                            wdata_q <= word;
                            idx_q   <= idx_d;
`ifdef LOADER_CHECKSUM_EN
                            sum_q   <= sum_q + word;
                            if (idx_d == cnt_q) state_q <= GET_CSUM;
`else
                            if (idx_d == cnt_q) begin
                                state_q <= DONE;
                                hold_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
`endif
                        end
`ifdef LOADER_CHECKSUM_EN
                        GET_CSUM: begin
                            hold_q <= 1'b0;
                            if (word == sum_q) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule
